// File: rtl/jk_count_monitor.sv
// Sequence monitor for a 3-bit up/down counter: checks +/-1 steps, counts wraps, flags illegal steps.
// Define JK_MON_ERRCNT_EN to build the saturating err_cnt register; otherwise err_cnt is tied to 0.
module jk_count_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              ud,
  input  logic              q2,
  input  logic              q1,
  input  logic              q0,
  output logic              valid,
  output logic              tc,
  output logic              dir_chg,
  output logic              err,
  output logic [2:0]        err_val,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;

  state_t              state_q, state_d;
  logic [2:0]          prev_q_q, prev_q_d;
  logic                prev_ud_q, prev_ud_d;
  logic                tc_q, tc_d;
  logic                dir_chg_q, dir_chg_d;
  logic                err_q, err_d;
  logic [2:0]          err_val_q, err_val_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic [2:0]          q_in;
  logic [2:0]          q_exp;
  logic                step_bad;
  logic                step_wrap;

  assign q_in  = {q2, q1, q0};
  // The step seen now was produced by the direction sampled on the previous edge.
  assign q_exp     = prev_ud_q ? (prev_q_q + 3'd1) : (prev_q_q - 3'd1);
  assign step_bad  = (q_in != q_exp);
  assign step_wrap = (prev_ud_q && (prev_q_q == 3'd7)) || (!prev_ud_q && (prev_q_q == 3'd0));

  always_comb begin
    state_d    = state_q;
    prev_q_d   = prev_q_q;
    prev_ud_d  = prev_ud_q;
    tc_d       = 1'b0;
    dir_chg_d  = 1'b0;
    err_d      = err_q;
    err_val_d  = err_val_q;
    wrap_cnt_d = wrap_cnt_q;

    if (!en) begin
      state_d = IDLE;
    end else if (clr) begin
      state_d    = ARM;
      err_d      = 1'b0;
      err_val_d  = 3'd0;
      wrap_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARM;
        ARM:     state_d = TRACK;
        TRACK:   state_d = TRACK;
        default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
        prev_q_d  = q_in;
        prev_ud_d = ud;
      end

      if (state_q == TRACK) begin
        dir_chg_d = (ud != prev_ud_q);
        if (step_bad) begin
          err_d = 1'b1;
          if (!err_q) err_val_d = q_in;
        end else if (step_wrap) begin
          tc_d       = 1'b1;
          wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_q_q   <= 3'd0;
      prev_ud_q  <= 1'b0;
      tc_q       <= 1'b0;
      dir_chg_q  <= 1'b0;
      err_q      <= 1'b0;
      err_val_q  <= 3'd0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q_q   <= prev_q_d;
      prev_ud_q  <= prev_ud_d;
      tc_q       <= tc_d;
      dir_chg_q  <= dir_chg_d;
      err_q      <= err_d;
      err_val_q  <= err_val_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

`ifdef JK_MON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (en && clr) begin
      err_cnt_d = '0;
    end else if (en && (state_q == TRACK) && step_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign valid    = (state_q == TRACK);
  assign tc       = tc_q;
  assign dir_chg  = dir_chg_q;
  assign err      = err_q;
  assign err_val  = err_val_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_jk_count_monitor.sv
// Bench for jk_count_monitor: directed scenarios then random traffic, checked against a sample-history model.
module tb_jk_count_monitor;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr;
  logic              ud;
  logic              q2;
  logic              q1;
  logic              q0;
  logic              valid;
  logic              tc;
  logic              dir_chg;
  logic              err;
  logic [2:0]        err_val;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  // What the counter currently presents on q; advanced by the bench each edge.
  logic [2:0] cnt;

  // Reference model: phase 0 = disabled, 1 = waiting for first sample, 2 = checking.
  int m_phase;
  int m_last_q;
  bit m_last_ud;
  bit m_err;
  int m_err_val;
  int m_err_cnt;
  int m_wraps;
  bit m_tc;
  bit m_dchg;

  always #5 clk = ~clk;

  jk_count_monitor #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .ud       (ud),
    .q2       (q2),
    .q1       (q1),
    .q0       (q0),
    .valid    (valid),
    .tc       (tc),
    .dir_chg  (dir_chg),
    .err      (err),
    .err_val  (err_val),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_last_q  = 0;
    m_last_ud = 1'b0;
    m_err     = 1'b0;
    m_err_val = 0;
    m_err_cnt = 0;
    m_wraps   = 0;
    m_tc      = 1'b0;
    m_dchg    = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit c, input bit u, input int qv);
    int want;
    m_tc   = 1'b0;
    m_dchg = 1'b0;
    if (!e) begin
      m_phase = 0;
    end else if (c) begin
      m_err     = 1'b0;
      m_err_val = 0;
      m_err_cnt = 0;
      m_wraps   = 0;
      m_phase   = 1;
    end else begin
      if (m_phase == 2) begin
        want = (m_last_q + (m_last_ud ? 1 : 7)) % 8;
        if (qv != want) begin
          if (!m_err) m_err_val = qv;
          m_err = 1'b1;
          if (m_err_cnt < (1 << ERR_W) - 1) m_err_cnt++;
        end else if ((m_last_q == 7 && qv == 0) || (m_last_q == 0 && qv == 7)) begin
          m_tc = 1'b1;
          m_wraps++;
        end
        m_dchg = (u != m_last_ud);
      end
      if (m_phase >= 1) begin
        m_last_q  = qv;
        m_last_ud = u;
      end
      m_phase = (m_phase == 0) ? 1 : 2;
    end
  endtask

  task automatic check_output();
    check_val("valid", valid, 32'(m_phase == 2));
    check_val("tc", tc, 32'(m_tc));
    check_val("dir_chg", dir_chg, 32'(m_dchg));
    check_val("err", err, 32'(m_err));
    check_val("err_val", err_val, m_err_val);
    check_val("wrap_cnt", wrap_cnt, m_wraps % (1 << WRAP_W));
`ifdef JK_MON_ERRCNT_EN
    check_val("err_cnt", err_cnt, m_err_cnt);
`else
    check_val("err_cnt", err_cnt, 0);
`endif
  endtask

  task automatic apply_stimulus(input bit e, input bit c, input bit u, input logic [2:0] qv);
    @(negedge clk);
    en  = e;
    clr = c;
    ud  = u;
    {q2, q1, q0} = qv;
    @(posedge clk);
    model_edge(e, c, u, int'(qv));
    #1;
    check_output();
  endtask

  task automatic count_step(input bit e, input bit c, input bit u);
    apply_stimulus(e, c, u, cnt);
    cnt = u ? cnt + 3'd1 : cnt - 3'd1;
  endtask

  initial begin
    int tc_seen;
    int dchg_seen;
    logic [2:0] bad;
    bit r_ud;
    bit r_en;
    bit r_clr;

    rst = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    ud  = 1'b0;
    {q2, q1, q0} = 3'd0;
    cnt = 3'd0;
    model_reset();
    #12;
    check_output();

    @(negedge clk);
    rst = 1'b1;

    $display("[TB] up count through a wrap");
    count_step(1'b1, 1'b0, 1'b1);
    check_val("valid_after_edge1", valid, 0);
    count_step(1'b1, 1'b0, 1'b1);
    check_val("valid_after_edge2", valid, 1);
    tc_seen = 0;
    for (int i = 0; i < 8; i++) begin
      count_step(1'b1, 1'b0, 1'b1);
      tc_seen += int'(tc);
    end
    check_val("up_tc_once", tc_seen, 1);
    check_val("up_wrap_cnt", wrap_cnt, 1);
    check_val("up_err", err, 0);

    $display("[TB] direction change then down through a wrap");
    count_step(1'b1, 1'b0, 1'b1);
    count_step(1'b1, 1'b0, 1'b0);
    check_val("dir_chg_pulse", dir_chg, 1);
    dchg_seen = 0;
    tc_seen   = 0;
    for (int i = 0; i < 6; i++) begin
      count_step(1'b1, 1'b0, 1'b0);
      dchg_seen += int'(dir_chg);
      tc_seen   += int'(tc);
    end
    check_val("dir_chg_single", dchg_seen, 0);
    check_val("down_tc_once", tc_seen, 1);
    check_val("down_wrap_cnt", wrap_cnt, 2);
    check_val("down_err", err, 0);

    $display("[TB] illegal jump 2 to 5");
    for (int i = 0; i < 8 && cnt != 3'd2; i++) count_step(1'b1, 1'b0, 1'b1);
    count_step(1'b1, 1'b0, 1'b1);
    cnt = 3'd5;
    count_step(1'b1, 1'b0, 1'b1);
    check_val("jump_err", err, 1);
    check_val("jump_err_val", err_val, 5);
    count_step(1'b1, 1'b0, 1'b1);
    check_val("resync_err_val", err_val, 5);
`ifdef JK_MON_ERRCNT_EN
    check_val("resync_err_cnt", err_cnt, 1);
`else
    check_val("resync_err_cnt", err_cnt, 0);
`endif

    $display("[TB] twenty illegal steps");
    for (int i = 0; i < 20; i++) begin
      bad = cnt + 3'(2 + $urandom_range(0, 5));
      apply_stimulus(1'b1, 1'b0, 1'b1, bad);
      cnt = bad + 3'd1;
    end
    check_val("sat_err_val", err_val, 5);
`ifdef JK_MON_ERRCNT_EN
    check_val("sat_err_cnt", err_cnt, 15);
`else
    check_val("sat_err_cnt", err_cnt, 0);
`endif

    $display("[TB] clear coincident with an illegal step");
    bad = cnt + 3'd3;
    apply_stimulus(1'b1, 1'b1, 1'b1, bad);
    cnt = bad + 3'd1;
    check_val("clr_err", err, 0);
    check_val("clr_wrap_cnt", wrap_cnt, 0);
    check_val("clr_err_cnt", err_cnt, 0);
    check_val("clr_valid", valid, 0);
    count_step(1'b1, 1'b0, 1'b1);
    check_val("clr_rearm_valid", valid, 1);
    for (int i = 0; i < 3; i++) count_step(1'b1, 1'b0, 1'b1);
    check_val("clr_no_err", err, 0);

    $display("[TB] enable gap with a count jump");
    for (int i = 0; i < 3; i++) count_step(1'b0, 1'b0, 1'b1);
    check_val("gap_valid", valid, 0);
    cnt = cnt + 3'd3;
    for (int i = 0; i < 4; i++) count_step(1'b1, 1'b0, 1'b1);
    check_val("gap_no_err", err, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      r_ud  = 1'($urandom_range(0, 1));
      r_en  = ($urandom_range(0, 31) != 0);
      r_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) cnt = 3'($urandom_range(0, 7));
      count_step(r_en, r_clr, r_ud);
    end

    $display("[TB] asynchronous reset mid-count");
    en  = 1'b1;
    clr = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_output();
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
